islemci_cok_cevrim: RTL and testbench

- Parametrised multi-cycle successor of the single-cycle core: RV32I-encoded integer subset, generic data width and register-file depth.
- Fetches through a valid/request handshake instead of sampling the instruction bus every edge.
- Adds a halt state for illegal/misaligned instructions and a retired-instruction counter.
- Sits between the instruction memory/ROM model and the board-level debug outputs.

---
 rtl/islemci_cok_cevrim_if.sv | 23 ++
 rtl/islemci_cok_cevrim.sv | 183 ++++++++++++++++++
 tb/tb_islemci_cok_cevrim.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/islemci_cok_cevrim_if.sv
// Instruction-fetch bus between the multi-cycle core (master) and instruction memory (slave).
interface islemci_cok_cevrim_if #(
  parameter int unsigned XLEN = 32
);
  logic [31:0]     buyruk;
  logic            buyruk_gecerli;
  logic            buyruk_istek;
  logic [XLEN-1:0] ps;

  modport master (
    input  buyruk,
    input  buyruk_gecerli,
    output buyruk_istek,
    output ps
  );

  modport slave (
    output buyruk,
    output buyruk_gecerli,
    input  buyruk_istek,
    input  ps
  );
endinterface

// File: rtl/islemci_cok_cevrim.sv
// Multi-cycle RV32I-subset core: fetch over a request/valid handshake, execute in one cycle,
// halt on illegal or misaligned instructions until reset.
module islemci_cok_cevrim #(
  parameter int unsigned     XLEN          = 32,
  parameter int unsigned     YAZMAC_SAYISI = 16,
  parameter int unsigned     IZLE_NO       = 10,
  parameter logic [XLEN-1:0] BASLANGIC_PS  = '0
) (
  input  logic                 saat,
  input  logic                 reset,
  islemci_cok_cevrim_if.master bus,
  output logic [XLEN-1:0]      yazmac_izle,
  output logic                 durdu,
  output logic [31:0]          emekli_sayac
);
  localparam int unsigned      SH_W     = $clog2(XLEN);
  localparam int unsigned      IDX_W    = (YAZMAC_SAYISI > 1) ? $clog2(YAZMAC_SAYISI) : 1;
  localparam logic [5:0]       SAYI     = 6'(YAZMAC_SAYISI);
  localparam logic [IDX_W-1:0] IZLE_IDX = IDX_W'(IZLE_NO);

  localparam logic [6:0] OpReg  = 7'h33;
  localparam logic [6:0] OpImm  = 7'h13;
  localparam logic [6:0] OpDal  = 7'h63;
  localparam logic [6:0] OpJal  = 7'h6F;
  localparam logic [6:0] OpJalr = 7'h67;

  typedef enum logic [1:0] {StGetir, StYurut, StDur} durum_e;

  durum_e          durum_q;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] ps_q;
  logic [31:0]     sayac_q;
  logic [XLEN-1:0] regs_q [YAZMAC_SAYISI];

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic       rd_ok, rs1_ok, rs2_ok;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];
  assign rd_ok  = {1'b0, rd} < SAYI;
  assign rs1_ok = {1'b0, rs1} < SAYI;
  assign rs2_ok = {1'b0, rs2} < SAYI;

  logic [XLEN-1:0] imm_i, imm_b, imm_j, rs1_val, rs2_val, ps_arti4, jalr_toplam;

  assign imm_i = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_b = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  // Out-of-range indices are already illegal; the truncated index only keeps the read in bounds.
  assign rs1_val = (rs1 == 5'd0 || !rs1_ok) ? '0 : regs_q[rs1[IDX_W-1:0]];
  assign rs2_val = (rs2 == 5'd0 || !rs2_ok) ? '0 : regs_q[rs2[IDX_W-1:0]];
  assign ps_arti4    = ps_q + XLEN'(4);
  assign jalr_toplam = rs1_val + imm_i;

  logic [XLEN-1:0] alu_b, alu_sonuc;
  logic [SH_W-1:0] shamt;

  assign alu_b = (opcode == OpReg) ? rs2_val : imm_i;
  assign shamt = alu_b[SH_W-1:0];

  always_comb begin
    alu_sonuc = '0;
    case (funct3)
      3'd0: alu_sonuc = (opcode == OpReg && funct7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'd1: alu_sonuc = rs1_val << shamt;
      3'd2: alu_sonuc = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(alu_b)};
      3'd3: alu_sonuc = {{(XLEN-1){1'b0}}, rs1_val < alu_b};
      3'd4: alu_sonuc = rs1_val ^ alu_b;
      3'd5: begin
        if (funct7[5]) alu_sonuc = $unsigned($signed(rs1_val) >>> shamt);
        else           alu_sonuc = rs1_val >> shamt;
      end
      3'd6: alu_sonuc = rs1_val | alu_b;
      default: alu_sonuc = rs1_val & alu_b;
    endcase
  end

  logic dal_al, dal_f3_ok;

  always_comb begin
    dal_al    = 1'b0;
    dal_f3_ok = 1'b1;
    case (funct3)
      3'd0: dal_al = rs1_val == rs2_val;
      3'd1: dal_al = rs1_val != rs2_val;
      3'd4: dal_al = $signed(rs1_val) < $signed(rs2_val);
      3'd5: dal_al = !($signed(rs1_val) < $signed(rs2_val));
      3'd6: dal_al = rs1_val < rs2_val;
      3'd7: dal_al = rs1_val >= rs2_val;
      default: dal_f3_ok = 1'b0;
    endcase
  end

  logic            yasal, yaz_en, ilerle;
  logic [XLEN-1:0] yaz_veri, yeni_ps;
  logic [6:0]      kaydir_izin;

  always_comb begin
    yasal    = 1'b0;
    yaz_en   = 1'b0;
    yaz_veri = ps_arti4;
    yeni_ps  = ps_arti4;
    // funct7 bits an immediate shift may set: shamt[5] on 64-bit, the arithmetic flag on srai.
    kaydir_izin = ((XLEN == 64) ? 7'b000_0001 : 7'b000_0000) |
                  ((funct3 == 3'd5) ? 7'b010_0000 : 7'b000_0000);
    case (opcode)
      OpReg: begin
        yasal    = rd_ok && rs1_ok && rs2_ok &&
                   (funct7 == 7'h00 ||
                    (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)));
        yaz_en   = 1'b1;
        yaz_veri = alu_sonuc;
      end
      OpImm: begin
        yasal    = rd_ok && rs1_ok &&
                   (funct3[1:0] != 2'b01 || (funct7 & ~kaydir_izin) == 7'h00);
        yaz_en   = 1'b1;
        yaz_veri = alu_sonuc;
      end
      OpDal: begin
        yasal = rs1_ok && rs2_ok && dal_f3_ok;
        if (dal_al) yeni_ps = ps_q + imm_b;
      end
      OpJal: begin
        yasal   = rd_ok;
        yaz_en  = 1'b1;
        yeni_ps = ps_q + imm_j;
      end
      OpJalr: begin
        yasal   = rd_ok && rs1_ok && (funct3 == 3'd0);
        yaz_en  = 1'b1;
        yeni_ps = {jalr_toplam[XLEN-1:1], 1'b0};
      end
      default: ;
    endcase
  end

  assign ilerle = yasal && (yeni_ps[1:0] == 2'b00);

  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      durum_q <= StGetir;
      ir_q    <= '0;
      ps_q    <= BASLANGIC_PS;
      sayac_q <= '0;
      for (int unsigned i = 0; i < YAZMAC_SAYISI; i++) regs_q[i] <= '0;
    end else begin
      case (durum_q)
        StGetir: begin
          if (bus.buyruk_gecerli) begin
            ir_q    <= bus.buyruk;
            durum_q <= StYurut;
          end
        end
        StYurut: begin
          if (ilerle) begin
            if (yaz_en && rd != 5'd0) regs_q[rd[IDX_W-1:0]] <= yaz_veri;
            ps_q    <= yeni_ps;
            sayac_q <= sayac_q + 32'd1;
            durum_q <= StGetir;
          end else begin
            durum_q <= StDur;
          end
        end
        default: durum_q <= StDur;
      endcase
    end
  end

  assign bus.buyruk_istek = reset && (durum_q == StGetir);
  assign bus.ps           = ps_q;
  assign durdu            = (durum_q == StDur);
  assign emekli_sayac     = sayac_q;
  assign yazmac_izle      = regs_q[IZLE_IDX];

endmodule

// File: tb/tb_islemci_cok_cevrim.sv
// Bench for islemci_cok_cevrim: directed table, reset/halt sequences, random stream vs model,
// plus a 64-bit build for the wide shifts.
module tb_islemci_cok_cevrim;
  logic saat = 1'b0;
  logic reset;
  always #5 saat = ~saat;

  islemci_cok_cevrim_if #(.XLEN(32)) bus ();
  islemci_cok_cevrim_if #(.XLEN(64)) bus64 ();

  logic [31:0] izle, sayac, sayac64;
  logic [63:0] izle64;
  logic        durdu, durdu64;

  islemci_cok_cevrim #(
    .XLEN(32), .YAZMAC_SAYISI(16), .IZLE_NO(10), .BASLANGIC_PS(32'h0)
  ) dut (
    .saat(saat), .reset(reset), .bus(bus),
    .yazmac_izle(izle), .durdu(durdu), .emekli_sayac(sayac)
  );

  islemci_cok_cevrim #(
    .XLEN(64), .YAZMAC_SAYISI(32), .IZLE_NO(10), .BASLANGIC_PS(64'h0)
  ) dut64 (
    .saat(saat), .reset(reset), .bus(bus64),
    .yazmac_izle(izle64), .durdu(durdu64), .emekli_sayac(sayac64)
  );

  int n_kontrol = 0;
  int n_hata    = 0;

  task automatic kontrol(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
    n_kontrol++;
    if (gercek !== beklenen) begin
      n_hata++;
      $display("FAIL %s: actual=%0h required=%0h", ad, gercek, beklenen);
    end
  endtask

  // Reference model: architectural state updated instruction by instruction.
  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_cnt;
  bit          m_dur;

  task automatic m_sifirla();
    for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
    m_pc = 32'h0; m_cnt = 32'h0; m_dur = 1'b0;
  endtask

  task automatic m_adim(input logic [31:0] w);
    logic [6:0] opc, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [31:0] a, b, ii, ib, ij, v, npc;
    bit ok, wr, t;
    opc = w[6:0]; rd = w[11:7]; f3 = w[14:12]; rs1 = w[19:15]; rs2 = w[24:20]; f7 = w[31:25];
    a  = (rs1 < 5'd16) ? m_r[rs1[3:0]] : 32'h0;
    b  = (rs2 < 5'd16) ? m_r[rs2[3:0]] : 32'h0;
    ii = {{20{w[31]}}, w[31:20]};
    ib = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    ij = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    ok = 1'b1; wr = 1'b0; v = 32'h0; t = 1'b0; npc = m_pc + 32'd4;
    case (opc)
      7'h33: begin
        if (rd >= 5'd16 || rs1 >= 5'd16 || rs2 >= 5'd16) ok = 1'b0;
        else begin
          wr = 1'b1;
          case ({f7, f3})
            10'h000: v = a + b;
            10'h100: v = a - b;
            10'h001: v = a << b[4:0];
            10'h002: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            10'h003: v = (a < b) ? 32'd1 : 32'd0;
            10'h004: v = a ^ b;
            10'h005: v = a >> b[4:0];
            10'h105: v = $unsigned($signed(a) >>> b[4:0]);
            10'h006: v = a | b;
            10'h007: v = a & b;
            default: ok = 1'b0;
          endcase
        end
      end
      7'h13: begin
        if (rd >= 5'd16 || rs1 >= 5'd16) ok = 1'b0;
        else begin
          wr = 1'b1;
          case (f3)
            3'd0: v = a + ii;
            3'd2: v = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
            3'd3: v = (a < ii) ? 32'd1 : 32'd0;
            3'd4: v = a ^ ii;
            3'd6: v = a | ii;
            3'd7: v = a & ii;
            3'd1: if (f7 == 7'h00) v = a << w[24:20]; else ok = 1'b0;
            default: begin
              if (f7 == 7'h00)      v = a >> w[24:20];
              else if (f7 == 7'h20) v = $unsigned($signed(a) >>> w[24:20]);
              else                  ok = 1'b0;
            end
          endcase
        end
      end
      7'h63: begin
        if (rs1 >= 5'd16 || rs2 >= 5'd16) ok = 1'b0;
        else begin
          case (f3)
            3'd0: t = (a == b);
            3'd1: t = (a != b);
            3'd4: t = ($signed(a) < $signed(b));
            3'd5: t = ($signed(a) >= $signed(b));
            3'd6: t = (a < b);
            3'd7: t = (a >= b);
            default: ok = 1'b0;
          endcase
          if (t) npc = m_pc + ib;
        end
      end
      7'h6F: begin
        if (rd >= 5'd16) ok = 1'b0;
        else begin wr = 1'b1; v = m_pc + 32'd4; npc = m_pc + ij; end
      end
      7'h67: begin
        if (rd >= 5'd16 || rs1 >= 5'd16 || f3 != 3'd0) ok = 1'b0;
        else begin wr = 1'b1; v = m_pc + 32'd4; npc = (a + ii) & 32'hFFFF_FFFE; end
      end
      default: ok = 1'b0;
    endcase
    if (!ok || npc[1:0] != 2'b00) m_dur = 1'b1;
    else begin
      if (wr && rd != 5'd0) m_r[rd[3:0]] = v;
      m_pc = npc;
      m_cnt = m_cnt + 32'd1;
    end
  endtask

  function automatic logic [4:0] r_idx();
    if ($urandom_range(0, 11) == 0) return 5'($urandom_range(16, 31));
    return 5'($urandom_range(0, 15));
  endfunction

  function automatic logic [31:0] rastgele();
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [11:0] imm;
    logic [12:0] ob;
    logic [20:0] oj;
    int k, off;
    rd = r_idx(); rs1 = r_idx(); rs2 = r_idx();
    f3  = 3'($urandom_range(0, 7));
    imm = 12'($urandom());
    k   = int'($urandom_range(0, 11));
    off = (int'($urandom_range(0, 16)) - 8) * (($urandom_range(0, 5) == 0) ? 2 : 4);
    ob  = 13'(off);
    oj  = 21'(off);
    f7  = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 15) == 0) f7 = 7'($urandom());
    case (k)
      0, 1, 2: return {f7, rs2, rs1, f3, rd, 7'h33};
      3, 4, 5, 6: begin
        if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = f7;
        return {imm, rs1, f3, rd, 7'h13};
      end
      7: return {ob[12], ob[10:5], rs2, rs1, f3, ob[4:1], ob[11], 7'h63};
      8: return {oj[20], oj[10:1], oj[11], oj[19:12], rd, 7'h6F};
      9: return {imm, rs1, ($urandom_range(0, 3) == 0) ? f3 : 3'd0, rd, 7'h67};
      default: return $urandom();
    endcase
  endfunction

  // Waits for a request, hands over one word, then lets the execute cycle complete.
  task automatic ver(input logic [31:0] ins);
    int n = 0;
    while (bus.buyruk_istek !== 1'b1 && n < 20) begin @(posedge saat); #1; n++; end
    if (bus.buyruk_istek !== 1'b1) begin
      n_kontrol++; n_hata++;
      $display("FAIL istek_bekle: actual=%b required=1", bus.buyruk_istek);
      return;
    end
    bus.buyruk = ins; bus.buyruk_gecerli = 1'b1;
    @(posedge saat); #1;
    kontrol("istek_yurut", bus.buyruk_istek, 1'b0);
    bus.buyruk = $urandom();  // garbage offered during execute must be ignored
    @(posedge saat); #1;
    bus.buyruk_gecerli = 1'b0;
  endtask

  task automatic ver64(input logic [31:0] ins);
    int n = 0;
    while (bus64.buyruk_istek !== 1'b1 && n < 20) begin @(posedge saat); #1; n++; end
    if (bus64.buyruk_istek !== 1'b1) begin
      n_kontrol++; n_hata++;
      $display("FAIL istek64_bekle: actual=%b required=1", bus64.buyruk_istek);
      return;
    end
    bus64.buyruk = ins; bus64.buyruk_gecerli = 1'b1;
    @(posedge saat); #1;
    bus64.buyruk_gecerli = 1'b0;
    @(posedge saat); #1;
  endtask

  task automatic sifirla();
    @(negedge saat);
    reset = 1'b0; bus.buyruk_gecerli = 1'b0; bus64.buyruk_gecerli = 1'b0;
    #2;
    kontrol("istek_reset", bus.buyruk_istek, 1'b0);
    @(negedge saat);
    reset = 1'b1;
    m_sifirla();
    @(posedge saat); #1;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] izle;
    logic [31:0] ps;
    logic [31:0] sayac;
    logic        durdu;
  } vektor_t;

  vektor_t tablo [10];

  initial begin
    #1000000;
    $display("FAIL zaman_asimi: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tablo[0] = '{32'h00500513, 32'd5,  32'd4,  32'd1, 1'b0};  // addi x10,x0,5
    tablo[1] = '{32'hFFD00593, 32'd5,  32'd8,  32'd2, 1'b0};  // addi x11,x0,-3
    tablo[2] = '{32'h00B50533, 32'd2,  32'd12, 32'd3, 1'b0};  // add x10,x10,x11
    tablo[3] = '{32'h00000463, 32'd2,  32'd20, 32'd4, 1'b0};  // beq x0,x0,+8
    tablo[4] = '{32'h010000EF, 32'd2,  32'd36, 32'd5, 1'b0};  // jal x1,+16
    tablo[5] = '{32'h40B50533, 32'd5,  32'd40, 32'd6, 1'b0};  // sub x10,x10,x11
    tablo[6] = '{32'h00008533, 32'd24, 32'd44, 32'd7, 1'b0};  // add x10,x1,x0
    tablo[7] = '{32'h00700013, 32'd24, 32'd48, 32'd8, 1'b0};  // addi x0,x0,7
    tablo[8] = '{32'h00000533, 32'd0,  32'd52, 32'd9, 1'b0};  // add x10,x0,x0
    tablo[9] = '{32'h00100A13, 32'd0,  32'd52, 32'd9, 1'b1};  // addi x20 -> illegal

    bus.buyruk = 32'h0; bus.buyruk_gecerli = 1'b0;
    bus64.buyruk = 32'h0; bus64.buyruk_gecerli = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    kontrol("reset_istek", bus.buyruk_istek, 1'b0);
    kontrol("reset_ps", bus.ps, 32'h0);
    kontrol("reset_durdu", durdu, 1'b0);
    kontrol("reset_sayac", sayac, 32'h0);
    m_sifirla();
    @(negedge saat) reset = 1'b1;
    repeat (3) @(posedge saat);
    #1;
    kontrol("bos_istek", bus.buyruk_istek, 1'b1);
    kontrol("bos_ps", bus.ps, 32'h0);
    kontrol("bos_sayac", sayac, 32'h0);
    kontrol("bos_izle", izle, 32'h0);

    for (int i = 0; i < 10; i++) begin
      ver(tablo[i].ins);
      kontrol($sformatf("tablo%0d_izle", i), izle, tablo[i].izle);
      kontrol($sformatf("tablo%0d_ps", i), bus.ps, tablo[i].ps);
      kontrol($sformatf("tablo%0d_sayac", i), sayac, tablo[i].sayac);
      kontrol($sformatf("tablo%0d_durdu", i), durdu, tablo[i].durdu);
    end

    // Halt is sticky: offered instructions are neither requested nor taken.
    bus.buyruk = 32'h00500513; bus.buyruk_gecerli = 1'b1;
    repeat (3) @(posedge saat);
    #1;
    bus.buyruk_gecerli = 1'b0;
    kontrol("dur_istek", bus.buyruk_istek, 1'b0);
    kontrol("dur_durdu", durdu, 1'b1);
    kontrol("dur_ps", bus.ps, 32'd52);
    kontrol("dur_izle", izle, 32'h0);

    sifirla();
    kontrol("sifir_durdu", durdu, 1'b0);
    ver(32'h0000_0000);
    kontrol("sifir_buyruk_durdu", durdu, 1'b1);
    kontrol("sifir_buyruk_ps", bus.ps, 32'h0);
    kontrol("sifir_buyruk_sayac", sayac, 32'h0);

    // Asynchronous reset while a latched addi is executing.
    sifirla();
    ver(32'h00500513);
    kontrol("async_on_izle", izle, 32'd5);
    bus.buyruk = 32'h00900513; bus.buyruk_gecerli = 1'b1;
    @(posedge saat); #1;
    bus.buyruk_gecerli = 1'b0;
    #2 reset = 1'b0;
    #1;
    kontrol("async_ps", bus.ps, 32'h0);
    kontrol("async_durdu", durdu, 1'b0);
    kontrol("async_istek", bus.buyruk_istek, 1'b0);
    kontrol("async_izle", izle, 32'h0);
    @(negedge saat) reset = 1'b1;
    m_sifirla();
    @(posedge saat); #1;
    kontrol("async_sonra_istek", bus.buyruk_istek, 1'b1);
    kontrol("async_sonra_izle", izle, 32'h0);
    kontrol("async_sonra_sayac", sayac, 32'h0);
    @(posedge saat); #1;
    kontrol("async_sonra_izle2", izle, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      w = rastgele();
      m_adim(w);
      ver(w);
      kontrol("rnd_ps", bus.ps, m_pc);
      kontrol("rnd_izle", izle, m_r[10]);
      kontrol("rnd_durdu", durdu, m_dur);
      kontrol("rnd_sayac", sayac, m_cnt);
      if (m_dur || durdu) sifirla();
    end

    sifirla();
    ver64(32'hFFF00513);  // addi x10,x0,-1
    kontrol("x64_addi", izle64, 64'hFFFF_FFFF_FFFF_FFFF);
    ver64(32'h03C55513);  // srli x10,x10,60
    kontrol("x64_srli", izle64, 64'hF);
    kontrol("x64_srli_ps", bus64.ps, 64'd8);
    ver64(32'hFFF00513);
    ver64(32'h43C55513);  // srai x10,x10,60
    kontrol("x64_srai", izle64, 64'hFFFF_FFFF_FFFF_FFFF);
    kontrol("x64_sayac", sayac64, 32'd4);
    kontrol("x64_durdu", durdu64, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_kontrol, n_hata);
    $finish;
  end
endmodule
